// File: rtl/dd_pkg.sv
// dd_pkg: shared state encoding and digit-count helper for the double dabble converter
package dd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  function automatic int min_digits(input int width);
    longint unsigned v;
    int d;
    v = (64'd1 << width) - 64'd1;
    d = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      d++;
    end
    return d;
  endfunction
endpackage

// File: rtl/dd_digit_adj.sv
// dd_digit_adj: add 3 to a BCD scratch digit that is 5 or more, no carry out
module dd_digit_adj (
  input  logic [3:0] d,
  output logic [3:0] q
);
  // a digit that would reach 10+ after doubling is pre-biased so the shift carries into the next digit
  always_comb q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/seq_double_dabble.sv
// seq_double_dabble: bit-serial binary-to-BCD converter with start/busy/done handshake
module seq_double_dabble
  import dd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  state_t          state, state_nx;
  logic [BIN_W-1:0] sh;
  logic [BW-1:0]    scr, adj;
  logic [CW-1:0]    cnt;
  logic             ovf_s, accept, last;
  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    dd_digit_adj u_adj (.d(scr[4*d +: 4]), .q(adj[4*d +: 4]));
  end
  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (state == SHIFT) && (cnt == '0);
  assign busy   = (state == SHIFT);
  assign done   = (state == DONE);
  // next state: accepting wins, then the final shift, DONE falls back to IDLE
  always_comb begin
    state_nx = state;
    state_nx = accept ? SHIFT : last ? DONE : (state == DONE) ? IDLE : state;
  end
  // state, shift datapath, and result registers; results only change when entering DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sh       <= '0;
      scr      <= '0;
      cnt      <= '0;
      ovf_s    <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        sh    <= bin;
        scr   <= '0;
        ovf_s <= 1'b0;
        cnt   <= CW'(BIN_W - 1);
      end else if (state == SHIFT) begin
        {scr, sh} <= {adj[BW-2:0], sh, 1'b0};
        ovf_s     <= ovf_s | adj[BW-1];
        cnt       <= cnt - CW'(1);
      end
      if (last) begin
        bcd      <= {adj[BW-2:0], sh[BIN_W-1]};
        overflow <= ovf_s | adj[BW-1];
      end
    end
  end
endmodule

// File: tb/tb_seq_double_dabble.sv
// tb_seq_double_dabble: directed checks of three converter configurations
module tb_seq_double_dabble;
  logic        clk = 1'b0;
  logic [2:0]  rsts = 3'b111;
  logic [2:0]  st = 3'b000;
  logic [15:0] b = '0;
  logic [2:0]  busy_v, done_v, ovf_v;
  logic [11:0] bcd0;
  logic [19:0] bcd1;
  logic [7:0]  bcd2;
  logic [19:0] bcdm [3];
  int n_chk = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  seq_double_dabble #(.BIN_W(8), .DIGITS(3)) u0 (.clk(clk), .rst(rsts[0]), .start(st[0]), .bin(b[7:0]),
    .busy(busy_v[0]), .done(done_v[0]), .bcd(bcd0), .overflow(ovf_v[0]));
  seq_double_dabble #(.BIN_W(16), .DIGITS(5)) u1 (.clk(clk), .rst(rsts[1]), .start(st[1]), .bin(b),
    .busy(busy_v[1]), .done(done_v[1]), .bcd(bcd1), .overflow(ovf_v[1]));
  seq_double_dabble #(.BIN_W(8), .DIGITS(2)) u2 (.clk(clk), .rst(rsts[2]), .start(st[2]), .bin(b[7:0]),
    .busy(busy_v[2]), .done(done_v[2]), .bcd(bcd2), .overflow(ovf_v[2]));
  assign bcdm[0] = {8'h0, bcd0};
  assign bcdm[1] = bcd1;
  assign bcdm[2] = {12'h0, bcd2};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [11:0] bcd8(input logic [7:0] v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction
  task automatic conv(input int i, input logic [15:0] v, input logic [19:0] eb, input logic eo, input int lat);
    int cnt, bz;
    cnt = 0;
    bz = 0;
    @(negedge clk);
    b = v;
    st[i] = 1'b1;
    do begin
      @(negedge clk);
      if (cnt == 0) st[i] = 1'b0;
      cnt++;
      bz += int'(busy_v[i]);
    end while (!done_v[i] && cnt < 40);
    check($sformatf("lat%0d_%0d", i, v), cnt, lat);
    check($sformatf("busy%0d_%0d", i, v), bz, lat - 1);
    check($sformatf("bcd%0d_%0d", i, v), bcdm[i], eb);
    check($sformatf("ovf%0d_%0d", i, v), ovf_v[i], eo);
    @(negedge clk);
    check($sformatf("pulse%0d_%0d", i, v), done_v[i], 1'b0);
    check($sformatf("hold%0d_%0d", i, v), bcdm[i], eb);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int nd, k;
    logic [7:0] cap [3];
    repeat (3) @(negedge clk);
    rsts = 3'b000;
    check("rst_busy", busy_v[0], 1'b0);
    check("rst_done", done_v[0], 1'b0);
    check("rst_bcd", bcd0, 12'h0);
    check("rst_ovf", ovf_v[0], 1'b0);
    conv(0, 16'd0, 20'h000, 1'b0, 9);
    conv(0, 16'd45, 20'h045, 1'b0, 9);
    conv(0, 16'd167, 20'h167, 1'b0, 9);
    conv(0, 16'd255, 20'h255, 1'b0, 9);
    conv(0, 16'd65, 20'h065, 1'b0, 9);
    conv(1, 16'd65535, 20'h65535, 1'b0, 17);
    conv(1, 16'd10000, 20'h10000, 1'b0, 17);
    conv(2, 16'd255, 20'h55, 1'b1, 9);
    conv(2, 16'd99, 20'h99, 1'b0, 9);
    nd = 0;
    for (int c = 0; c < 3; c++) cap[c] = 8'((c * 9) * 29 + 11);
    for (k = 0; k <= 27; k++) begin
      @(negedge clk);
      if (k > 0 && done_v[0]) begin
        check("hs_when", k, 9 * (nd + 1));
        if (nd < 3) check($sformatf("hs_bcd%0d", nd), bcd0, bcd8(cap[nd]));
        nd++;
      end
      b = 16'(8'(k * 29 + 11));
      st[0] = (k < 27);
    end
    check("hs_count", nd, 3);
    conv(0, 16'd123, 20'h123, 1'b0, 9);
    @(negedge clk);
    b = 16'd200;
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (3) @(negedge clk);
    rsts[0] = 1'b1;
    @(negedge clk);
    rsts[0] = 1'b0;
    check("mid_busy", busy_v[0], 1'b0);
    check("mid_done", done_v[0], 1'b0);
    check("mid_bcd", bcd0, 12'h0);
    check("mid_ovf", ovf_v[0], 1'b0);
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      nd += int'(done_v[0]);
    end
    check("mid_nodone", nd, 0);
    conv(0, 16'd7, 20'h007, 1'b0, 9);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
